skid_credit: RTL and testbench

- Parametrised successor to the single-stage skid buffer. Carries an elastic valid/ready stream across FEED_STAGES forward register stages that do not stall.
- Backpressure is credit-based. irdy is a pure flop output, with no combinational path from ordy. A DEPTH-entry output FIFO absorbs all in-flight words.
- Adds an occupancy output and a synchronous flush.
- Used to retime long valid/ready routes between dataflow layers.

---
 rtl/skid_credit.sv | 148 ++++++++++++++
 tb/tb_skid_credit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skid_credit.sv
// Credit-based elastic pipe: non-stalling feed stages, a circular FIFO and a
// registered fall-through output stage. irdy is a flop driven from the credit count.
module skid_credit #(
  parameter  int DATA_WIDTH  = 13,
  parameter  int FEED_STAGES = 2,
  parameter  int DEPTH       = FEED_STAGES + 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] idat,
  input  logic                  ivld,
  output logic                  irdy,
  output logic [DATA_WIDTH-1:0] odat,
  output logic                  ovld,
  input  logic                  ordy,
  output logic [CW-1:0]         count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (FEED_STAGES < 0 || FEED_STAGES > 7) begin : g_bad_feed
    $error("skid_credit: FEED_STAGES must be in 0..7");
  end
  if (DEPTH < FEED_STAGES + 2) begin : g_bad_depth
    $error("skid_credit: DEPTH must be at least FEED_STAGES+2");
  end

  logic                  irdy_q, irdy_d;
  logic                  ovld_q, ovld_d;
  logic [DATA_WIDTH-1:0] odat_q, odat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         fc_q, fc_d;
  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc, deq, ld, we, pop;
  logic                  wr_v;
  logic [DATA_WIDTH-1:0] wr_d;

  assign acc = ivld & irdy_q;
  assign deq = ovld_q & ordy;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Feed path: plain shift registers that advance every cycle; flush kills the valids.
  if (FEED_STAGES == 0) begin : g_direct
    assign wr_v = acc;
    assign wr_d = idat;
  end else begin : g_feed
    logic [FEED_STAGES-1:0]                 vld_pipe;
    logic [FEED_STAGES-1:0][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
      end else if (flush) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= acc;
        for (int k = 1; k < FEED_STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_pipe[0] <= idat;
      for (int k = 1; k < FEED_STAGES; k++) dat_pipe[k] <= dat_pipe[k-1];
    end

    assign wr_v = vld_pipe[FEED_STAGES-1];
    assign wr_d = dat_pipe[FEED_STAGES-1];
  end

  // Output register refills whenever it is empty or being drained this edge.
  // An arriving word bypasses the memory only when the memory is empty.
  always_comb begin
    ld     = ~ovld_q | deq;
    pop    = 1'b0;
    we     = 1'b0;
    wp_d   = wp_q;
    rp_d   = rp_q;
    fc_d   = fc_q;
    ovld_d = ovld_q;
    odat_d = odat_q;
    if (flush) begin
      wp_d   = '0;
      rp_d   = '0;
      fc_d   = '0;
      ovld_d = 1'b0;
    end else begin
      if (ld) begin
        if (fc_q != '0) begin
          pop    = 1'b1;
          odat_d = mem_q[rp_q];
          ovld_d = 1'b1;
          rp_d   = inc(rp_q);
        end else if (wr_v) begin
          odat_d = wr_d;
          ovld_d = 1'b1;
        end else begin
          ovld_d = 1'b0;
        end
      end
      we = wr_v & ~(ld & (fc_q == '0));
      if (we) wp_d = inc(wp_q);
      fc_d = fc_q + CW'(we) - CW'(pop);
    end
  end

  // Credits cover feed stages, memory and output register together.
  always_comb begin
    cnt_d  = flush ? '0 : cnt_q + CW'(acc) - CW'(deq);
    irdy_d = (cnt_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irdy_q <= 1'b0;
      ovld_q <= 1'b0;
      odat_q <= '0;
      cnt_q  <= '0;
      fc_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      irdy_q <= irdy_d;
      ovld_q <= ovld_d;
      odat_q <= odat_d;
      cnt_q  <= cnt_d;
      fc_q   <= fc_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wp_q] <= wr_d;
  end

  assign irdy  = irdy_q;
  assign ovld  = ovld_q;
  assign odat  = odat_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_skid_credit.sv
// Bench for skid_credit: two directed instances plus a soak array over every
// FEED_STAGES, each checked each cycle against a queue-of-words model.
module tb_skid_credit;
  localparam int NC = 18;
  localparam int DW = 13;

  typedef struct {
    logic [DW-1:0] d;
    int            av;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         d_ivld, d_ordy, d_flush;
  logic [1:0][DW-1:0] d_idat;
  wire  [NC-1:0]          o_irdy, o_ovld, s_done;
  wire  [NC-1:0][DW-1:0]  o_odat;
  wire  [NC-1:0][7:0]     o_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h @%0t", id, nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int F  = (g < 2) ? 2 : ((g < 10) ? g - 2 : g - 10);
    localparam int D  = (g == 0) ? 4 : ((g == 1) ? 6 : ((g < 10) ? F + 2 : F + 5));
    localparam int CW = $clog2(D + 1);

    logic          ivld, ordy, flush;
    logic [DW-1:0] idat;
    logic          irdy, ovld;
    logic [DW-1:0] odat;
    logic [CW-1:0] count;

    skid_credit #(.DATA_WIDTH(DW), .FEED_STAGES(F), .DEPTH(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .idat(idat), .ivld(ivld),
      .irdy(irdy), .odat(odat), .ovld(ovld), .ordy(ordy), .count(count)
    );

    // Model: a word is visible F+1 cycles after its accept cycle, once it is at the head.
    ent_t q[$];
    int   cyc   = 0;
    int   ndel  = 0;
    bit   alive = 1'b0;
    bit   took  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        alive = 1'b0;
        took  = 1'b0;
      end else begin
        took = 1'b0;
        if (!alive) begin
          alive = 1'b1;
        end else begin
          bit eov, erdy;
          eov  = (q.size() > 0) && (q[0].av <= cyc);
          erdy = (q.size() < D);
          if (eov && ordy) begin
            void'(q.pop_front());
            ndel++;
          end
          if (flush) q.delete();
          else if (ivld && erdy) begin
            q.push_back('{d: idat, av: cyc + F + 1});
            took = 1'b1;
          end
        end
        cyc++;
      end
    end

    always @(negedge clk) begin
      bit eov;
      eov = alive && (q.size() > 0) && (q[0].av <= cyc);
      chk(g, "irdy",  32'(irdy),  32'(alive && (q.size() < D)));
      chk(g, "ovld",  32'(ovld),  32'(eov));
      chk(g, "count", 32'(count), q.size());
      if (eov)         chk(g, "odat", 32'(odat), 32'(q[0].d));
      else if (!rst_n) chk(g, "odat in reset", 32'(odat), 0);
    end

    if (g < 2) begin : g_dir
      assign ivld  = d_ivld[g];
      assign idat  = d_idat[g];
      assign ordy  = d_ordy[g];
      assign flush = d_flush[g];
    end else begin : g_rnd
      logic          r_ivld = 1'b0;
      logic          r_ordy = 1'b0;
      logic [DW-1:0] r_idat = '0;
      int            stall  = 0;
      assign ivld  = r_ivld;
      assign idat  = r_idat;
      assign ordy  = r_ordy;
      assign flush = 1'b0;
      initial begin
        forever begin
          tick();
          if (took || !r_ivld) begin
            if ($urandom_range(52) == 0) r_ivld = 1'b0;
            else begin
              r_ivld = 1'b1;
              r_idat = DW'($urandom);
            end
          end
          if (stall > 0) begin
            stall--;
            r_ordy = 1'b0;
          end else if ($urandom_range(399) == 0) begin
            stall  = 2 * F + 4;
            r_ordy = 1'b0;
          end else begin
            r_ordy = ($urandom_range(18) != 0);
          end
        end
      end
    end

    assign o_irdy[g] = irdy;
    assign o_ovld[g] = ovld;
    assign o_odat[g] = odat;
    assign o_cnt[g]  = 8'(count);
    assign s_done[g] = (g < 2) ? 1'b1 : (ndel >= 15000);
  end

  initial begin
    int   k, got, exp_cnt;
    logic acc;
    bit   seen;
    d_ivld = '0; d_ordy = '0; d_flush = '0; d_idat = '0;

    // Reset state, then release away from the clock edge.
    repeat (2) @(negedge clk);
    chk(0, "rst irdy",  32'(o_irdy[0]), 0);
    chk(0, "rst ovld",  32'(o_ovld[0]), 0);
    chk(0, "rst count", 32'(o_cnt[0]),  0);
    #2 rst_n = 1'b1;
    tick();

    // Full-rate stream on FEED_STAGES=2, DEPTH=4: word j visible in cycle j+3.
    d_ordy[0] = 1'b1;
    for (int j = 0; j < 262; j++) begin
      d_ivld[0] = (j < 256);
      d_idat[0] = DW'(j);
      @(negedge clk);
      exp_cnt = ((j < 256) ? j : 256) - ((j < 3) ? 0 : ((j - 3 < 256) ? j - 3 : 256));
      chk(0, "stream irdy",  32'(o_irdy[0]), 1);
      chk(0, "stream ovld",  32'(o_ovld[0]), 32'(j >= 3 && j < 259));
      chk(0, "stream count", 32'(o_cnt[0]),  exp_cnt);
      if (j >= 3 && j < 259) chk(0, "stream odat", 32'(o_odat[0]), j - 3);
      tick();
    end
    d_ivld[0] = 1'b0;

    // Fill DEPTH=6 with ordy low: exactly six words go in, head stays put.
    k = 0;
    d_ordy[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      d_ivld[1] = 1'b1;
      d_idat[1] = DW'(32'h100 + k);
      @(negedge clk);
      chk(1, "fill irdy",  32'(o_irdy[1]), 32'(j < 6));
      chk(1, "fill count", 32'(o_cnt[1]),  (j < 6) ? j : 6);
      chk(1, "fill ovld",  32'(o_ovld[1]), 32'(j >= 3));
      if (j >= 3) chk(1, "fill odat hold", 32'(o_odat[1]), 32'h100);
      acc = o_irdy[1];
      tick();
      if (acc) k++;
    end
    chk(1, "fill accepted", k, 6);

    d_ordy[1] = 1'b1;
    got = 0;
    for (int j = 0; j < 25; j++) begin
      d_ivld[1] = (k < 8);
      d_idat[1] = DW'(32'h100 + k);
      @(negedge clk);
      if (j == 0) begin
        chk(1, "drain0 irdy",  32'(o_irdy[1]), 0);
        chk(1, "drain0 count", 32'(o_cnt[1]),  6);
      end
      if (j == 1) begin
        chk(1, "drain1 irdy",  32'(o_irdy[1]), 1);
        chk(1, "drain1 count", 32'(o_cnt[1]),  5);
      end
      if (j == 2) chk(1, "drain2 count", 32'(o_cnt[1]), 5);
      if (o_ovld[1]) begin
        chk(1, "drain order", 32'(o_odat[1]), 32'h100 + got);
        got++;
      end
      acc = o_irdy[1] && d_ivld[1];
      tick();
      if (acc) k++;
    end
    d_ivld[1] = 1'b0;
    chk(1, "drain delivered", got, 8);

    // Simultaneous accept and deliver at count=5.
    d_ordy[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      d_ivld[1] = 1'b1;
      d_idat[1] = DW'(32'h200 + j);
      tick();
    end
    d_ivld[1] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk(1, "c5 count", 32'(o_cnt[1]),  5);
    chk(1, "c5 odat",  32'(o_odat[1]), 32'h200);
    d_ivld[1] = 1'b1; d_idat[1] = DW'(32'h205); d_ordy[1] = 1'b1;
    tick();
    d_ivld[1] = 1'b0; d_ordy[1] = 1'b0;
    @(negedge clk);
    chk(1, "c5 same count", 32'(o_cnt[1]),  5);
    chk(1, "c5 same irdy",  32'(o_irdy[1]), 1);
    chk(1, "c5 next odat",  32'(o_odat[1]), 32'h201);
    d_ordy[1] = 1'b1;
    repeat (12) tick();

    // count=1: head leaves as a new word enters the feed path.
    d_ordy[1] = 1'b0;
    d_ivld[1] = 1'b1; d_idat[1] = DW'(32'h210);
    tick();
    d_ivld[1] = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk(1, "c1 count", 32'(o_cnt[1]),  1);
    chk(1, "c1 odat",  32'(o_odat[1]), 32'h210);
    d_ivld[1] = 1'b1; d_idat[1] = DW'(32'h211); d_ordy[1] = 1'b1;
    tick();
    d_ivld[1] = 1'b0;
    @(negedge clk);
    chk(1, "c1 same count", 32'(o_cnt[1]),  1);
    chk(1, "c1 gap ovld a", 32'(o_ovld[1]), 0);
    tick();
    @(negedge clk);
    chk(1, "c1 gap ovld b", 32'(o_ovld[1]), 0);
    tick();
    @(negedge clk);
    chk(1, "c1 arrive ovld", 32'(o_ovld[1]), 1);
    chk(1, "c1 arrive odat", 32'(o_odat[1]), 32'h211);
    tick();
    @(negedge clk);
    chk(1, "c1 empty count", 32'(o_cnt[1]), 0);
    tick();

    // Flush at count=4 with a word on the input that must be dropped.
    d_ordy[1] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      d_ivld[1] = 1'b1;
      d_idat[1] = DW'(32'h300 + j);
      tick();
    end
    d_ivld[1] = 1'b0;
    tick();
    d_flush[1] = 1'b1; d_ivld[1] = 1'b1; d_idat[1] = DW'(32'h0AA);
    @(negedge clk);
    chk(1, "pre-flush count", 32'(o_cnt[1]), 4);
    tick();
    d_flush[1] = 1'b0; d_ivld[1] = 1'b0; d_ordy[1] = 1'b1;
    @(negedge clk);
    chk(1, "flush count", 32'(o_cnt[1]),  0);
    chk(1, "flush ovld",  32'(o_ovld[1]), 0);
    chk(1, "flush irdy",  32'(o_irdy[1]), 1);
    repeat (4) tick();
    d_ivld[1] = 1'b1; d_idat[1] = DW'(32'h1AB);
    tick();
    d_ivld[1] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clk);
      if (o_ovld[1]) begin
        chk(1, "post-flush first word", 32'(o_odat[1]), 32'h1AB);
        seen = 1'b1;
      end
      tick();
    end
    chk(1, "post-flush word seen", 32'(seen), 1);

    // Async reset pulse in the middle of the soak traffic.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) begin
      chk(i, "async rst irdy",  32'(o_irdy[i]), 0);
      chk(i, "async rst ovld",  32'(o_ovld[i]), 0);
      chk(i, "async rst count", 32'(o_cnt[i]),  0);
      chk(i, "async rst odat",  32'(o_odat[i]), 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int t = 0; t < 60000 && !(&s_done); t++) @(posedge clk);
    chk(-1, "soak finished within budget", 32'(&s_done), 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
